pic_prio_ctrl: RTL and testbench

Parametrised, fully synchronous priority-resolution and acknowledge core for the programmable interrupt controller. It generalises the 8-input control logic to NIRQ request lines and provides:
- per-line edge/level triggering;
- fixed or rotating priority;
- fully nested in-service masking;
- a two-pulse INTA handshake;
- automatic or commanded EOI.

It sits between the request pins and the data-bus buffer, and is configured by the command decoder.

---
 rtl/pic_prio_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_pic_prio_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_prio_ctrl.sv
// pic_prio_ctrl: priority resolution and two-pulse INTA acknowledge core
// for a programmable interrupt controller with NIRQ request lines.
// Handshake: there is no valid/ready pair here. The CPU strobe inta is
// active-low. Each high-to-low transition seen on consecutive clocks is one
// acknowledge pulse, and holding it low never repeats a pulse. vec_valid is
// a single-cycle strobe that qualifies vector.
// The request line to the CPU is named int_o because "int" is a reserved word.
module pic_prio_ctrl #(
  parameter int NIRQ  = 8,
  parameter int VBITS = 8,
  localparam int IDW  = $clog2(NIRQ)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NIRQ-1:0]  irq,
  input  logic             cfg_we,
  input  logic [NIRQ-1:0]  imr_in,
  input  logic [VBITS-1:0] base_in,
  input  logic             ltim,
  input  logic             rot,
  input  logic             aeoi,
  input  logic             eoi,
  input  logic             eoi_sl,
  input  logic [IDW-1:0]   eoi_lvl,
  input  logic             inta,
  output logic             int_o,
  output logic [VBITS-1:0] vector,
  output logic             vec_valid,
  output logic [NIRQ-1:0]  isr_o,
  output logic [NIRQ-1:0]  irr_o,
  output logic [1:0]       dbg_state_o,
  output logic [IDW-1:0]   dbg_lp_o
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACK1_WAIT = 2'd1,  // ACK1 taken, waiting for inta to return high
    ST_ACK2_WAIT = 2'd2   // waiting for the second falling edge
  } state_e;

  // The low IDW bits of the vector carry the line id, not the base.
  localparam logic [VBITS-1:0] ID_MASK = VBITS'(NIRQ - 1);

  state_e           state_q, state_d;
  logic [NIRQ-1:0]  irq_q, irq_d;
  logic             inta_q, inta_d;
  logic [NIRQ-1:0]  irr_q, irr_d;
  logic [NIRQ-1:0]  isr_q, isr_d;
  logic [NIRQ-1:0]  imr_q, imr_d;
  logic [VBITS-1:0] base_q, base_d;
  logic [IDW-1:0]   lp_q, lp_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             spur_q, spur_d;
  logic             ltim_q, ltim_d;
  logic             rot_q, rot_d;
  logic             aeoi_q, aeoi_d;
  logic             int_q, int_d;
  logic [VBITS-1:0] vector_q, vector_d;
  logic             vec_valid_q, vec_valid_d;

  logic [NIRQ-1:0]  req_v;
  logic [IDW-1:0]   scan_idx;
  logic             win_vld, top_vld;
  logic [IDW-1:0]   win_id, win_rank, top_id, top_rank;
  logic [NIRQ-1:0]  rise;
  logic             ack_edge;
  logic             eoi_hit;
  logic [IDW-1:0]   eoi_id;
  logic [NIRQ-1:0]  irr_clr;
  logic [NIRQ-1:0]  irr_base;

  // Lowest-rank pending unmasked request and lowest-rank in-service level.
  // The scan runs from the worst rank to the best, so the last hit wins.
  always_comb begin
    req_v    = irr_q & ~imr_q;
    scan_idx = '0;
    win_vld  = 1'b0;
    win_id   = '0;
    win_rank = '0;
    top_vld  = 1'b0;
    top_id   = '0;
    top_rank = '0;
    for (int r = NIRQ - 1; r >= 0; r--) begin
      scan_idx = lp_q + IDW'(1) + IDW'(r);
      if (req_v[scan_idx]) begin
        win_vld  = 1'b1;
        win_id   = scan_idx;
        win_rank = IDW'(r);
      end
      if (isr_q[scan_idx]) begin
        top_vld  = 1'b1;
        top_id   = scan_idx;
        top_rank = IDW'(r);
      end
    end
  end

  // Next-state logic: configuration, EOI, the acknowledge FSM and request capture.
  always_comb begin
    state_d     = state_q;
    irq_d       = irq;
    inta_d      = inta;
    isr_d       = isr_q;
    imr_d       = imr_q;
    base_d      = base_q;
    lp_d        = lp_q;
    id_d        = id_q;
    spur_d      = spur_q;
    ltim_d      = ltim_q;
    rot_d       = rot_q;
    aeoi_d      = aeoi_q;
    vector_d    = vector_q;
    vec_valid_d = 1'b0;
    irr_clr     = '0;
    eoi_hit     = 1'b0;
    eoi_id      = '0;

    rise     = irq & ~irq_q;
    ack_edge = inta_q & ~inta;

    if (cfg_we) begin
      imr_d  = imr_in;
      base_d = base_in;
      ltim_d = ltim;
      rot_d  = rot;
      aeoi_d = aeoi;
    end

    // EOI works on the isr as it stood before any ACK1 set this cycle.
    if (eoi) begin
      if (eoi_sl) begin
        eoi_hit = 1'b1;
        eoi_id  = eoi_lvl;
      end else if (top_vld) begin
        eoi_hit = 1'b1;
        eoi_id  = top_id;
      end
    end
    if (eoi_hit) begin
      isr_d[eoi_id] = 1'b0;
      if (rot_q) lp_d = eoi_id;
    end

    case (state_q)
      ST_IDLE: begin
        if (ack_edge) begin
          state_d = ST_ACK1_WAIT;
          if (win_vld) begin
            id_d            = win_id;
            isr_d[win_id]   = 1'b1;
            irr_clr[win_id] = 1'b1;
            spur_d          = 1'b0;
          end else begin
            id_d   = IDW'(NIRQ - 1);
            spur_d = 1'b1;
          end
        end
      end
      ST_ACK1_WAIT: begin
        if (inta) state_d = ST_ACK2_WAIT;
      end
      ST_ACK2_WAIT: begin
        if (ack_edge) begin
          state_d     = ST_IDLE;
          vector_d    = (base_q & ~ID_MASK) | VBITS'(id_q);
          vec_valid_d = 1'b1;
          if (aeoi_q && !spur_q) begin
            isr_d[id_q] = 1'b0;
            if (rot_q) lp_d = id_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh edge beats the acknowledge clear of the same line.
    irr_base = ltim_q ? irq : irr_q;
    irr_d    = (irr_base & ~irr_clr) | rise;

    int_d = (state_q == ST_IDLE) && win_vld && (!top_vld || (win_rank < top_rank));
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      irq_q       <= '0;
      inta_q      <= 1'b1;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '0;
      base_q      <= '0;
      lp_q        <= IDW'(NIRQ - 1);
      id_q        <= '0;
      spur_q      <= 1'b0;
      ltim_q      <= 1'b0;
      rot_q       <= 1'b0;
      aeoi_q      <= 1'b0;
      int_q       <= 1'b0;
      vector_q    <= '0;
      vec_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      inta_q      <= inta_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      base_q      <= base_d;
      lp_q        <= lp_d;
      id_q        <= id_d;
      spur_q      <= spur_d;
      ltim_q      <= ltim_d;
      rot_q       <= rot_d;
      aeoi_q      <= aeoi_d;
      int_q       <= int_d;
      vector_q    <= vector_d;
      vec_valid_q <= vec_valid_d;
    end
  end

  assign int_o       = int_q;
  assign vector      = vector_q;
  assign vec_valid   = vec_valid_q;
  assign isr_o       = isr_q;
  assign irr_o       = irr_q;
  assign dbg_state_o = state_q;
  assign dbg_lp_o    = lp_q;

endmodule

// File: tb/tb_pic_prio_ctrl.sv
// Testbench for pic_prio_ctrl: an 8-line instance for the main scenarios,
// and a 32-line instance for wide vectors and reset during ACK2_WAIT.
module tb_pic_prio_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- 8-line instance ----------------
  logic       rstn;
  logic [7:0] irq, imr_in, base_in;
  logic       cfg_we, ltim, rot, aeoi, eoi, eoi_sl, inta;
  logic [2:0] eoi_lvl;
  logic       int_o, vec_valid;
  logic [7:0] vector, isr_o, irr_o;
  logic [1:0] dbg_state;
  logic [2:0] dbg_lp;

  pic_prio_ctrl #(.NIRQ(8), .VBITS(8)) u_dut (
    .clk(clk), .rstn(rstn), .irq(irq), .cfg_we(cfg_we), .imr_in(imr_in),
    .base_in(base_in), .ltim(ltim), .rot(rot), .aeoi(aeoi), .eoi(eoi),
    .eoi_sl(eoi_sl), .eoi_lvl(eoi_lvl), .inta(inta), .int_o(int_o),
    .vector(vector), .vec_valid(vec_valid), .isr_o(isr_o), .irr_o(irr_o),
    .dbg_state_o(dbg_state), .dbg_lp_o(dbg_lp)
  );

  // ---------------- 32-line instance ----------------
  logic        rstn32;
  logic [31:0] irq32, imr32;
  logic [7:0]  base32;
  logic        cfg_we32, eoi32, inta32;
  logic        int32, vv32;
  logic [7:0]  vector32;
  logic [31:0] isr32, irr32;
  logic [1:0]  state32;
  logic [4:0]  lp32;

  pic_prio_ctrl #(.NIRQ(32), .VBITS(8)) u_dut32 (
    .clk(clk), .rstn(rstn32), .irq(irq32), .cfg_we(cfg_we32), .imr_in(imr32),
    .base_in(base32), .ltim(1'b0), .rot(1'b0), .aeoi(1'b0), .eoi(eoi32),
    .eoi_sl(1'b0), .eoi_lvl(5'd0), .inta(inta32), .int_o(int32),
    .vector(vector32), .vec_valid(vv32), .isr_o(isr32), .irr_o(irr32),
    .dbg_state_o(state32), .dbg_lp_o(lp32)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp32_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Each vec_valid strobe consumes one expected vector.
  always @(negedge clk) begin
    if (vec_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("vec_unexp", vec_valid, 1'b0);
      else chk("vector", vector, exp_q.pop_front());
    end
    if (vv32 === 1'b1) begin
      if (exp32_q.size() == 0) chk("vec32_unexp", vv32, 1'b0);
      else chk("vector32", vector32, exp32_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [7:0] m, input logic [7:0] b,
                     input logic l, input logic r, input logic a);
    cfg_we = 1'b1; imr_in = m; base_in = b; ltim = l; rot = r; aeoi = a;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_irq(input logic [7:0] v);
    irq = v;
    tick(1);
    irq = 8'h00;
    tick(1);
  endtask

  task automatic ack1();
    inta = 1'b0; tick(1);
    inta = 1'b1; tick(1);
  endtask

  task automatic ack2(input logic [7:0] exp_vec);
    exp_q.push_back(exp_vec);
    inta = 1'b0; tick(1);
    inta = 1'b1; tick(1);
    chk("vq_empty", exp_q.size(), 0);
  endtask

  task automatic ns_eoi();
    eoi = 1'b1; eoi_sl = 1'b0; tick(1);
    eoi = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; irq = '0; imr_in = '0; base_in = '0; cfg_we = 1'b0;
    ltim = 1'b0; rot = 1'b0; aeoi = 1'b0; eoi = 1'b0; eoi_sl = 1'b0;
    eoi_lvl = '0; inta = 1'b1;
    rstn32 = 1'b0; irq32 = '0; imr32 = '0; base32 = '0; cfg_we32 = 1'b0;
    eoi32 = 1'b0; inta32 = 1'b1;
    tick(2);
    chk("rst_int", int_o, 0);
    chk("rst_vector", vector, 0);
    chk("rst_vv", vec_valid, 0);
    chk("rst_isr", isr_o, 0);
    chk("rst_irr", irr_o, 0);
    chk("rst_lp", dbg_lp, 7);
    chk("rst_state", dbg_state, 0);
    rstn = 1'b1; rstn32 = 1'b1;
    tick(1);

    // edge-triggered, fixed priority, single request on line 3
    cfg(8'h00, 8'h20, 1'b0, 1'b0, 1'b0);
    irq = 8'h08;
    tick(1);
    irq = 8'h00;
    chk("e_irr_set", irr_o, 8'h08);
    chk("e_int_lat1", int_o, 0);
    tick(1);
    chk("e_int_lat2", int_o, 1);
    ack1();
    chk("e_int_drop", int_o, 0);
    chk("e_isr_ack1", isr_o, 8'h08);
    chk("e_irr_clr", irr_o, 8'h00);
    chk("e_state", dbg_state, 2);
    ack2(8'h23);
    chk("e_vector_hold", vector, 8'h23);
    chk("e_int_insvc", int_o, 0);
    chk("e_isr_hold", isr_o, 8'h08);
    ns_eoi();
    chk("e_isr_eoi", isr_o, 8'h00);
    chk("e_lp_fixed", dbg_lp, 7);

    // nesting: higher priority interrupts an in-service level
    pulse_irq(8'h20);
    ack1(); ack2(8'h25);
    pulse_irq(8'h04);
    chk("n_int_hi", int_o, 1);
    ack1(); ack2(8'h22);
    chk("n_isr_nest", isr_o, 8'h24);
    ns_eoi();
    chk("n_eoi_top", isr_o, 8'h20);
    // lower priority is held off until line 5 is retired
    pulse_irq(8'h40);
    chk("n_int_lo", int_o, 0);
    ns_eoi();
    chk("n_isr_clr", isr_o, 8'h00);
    tick(1);
    chk("n_int_after", int_o, 1);
    ack1(); ack2(8'h26);
    ns_eoi();
    chk("n_isr_end", isr_o, 8'h00);

    // rotating priority
    cfg(8'h00, 8'h20, 1'b0, 1'b1, 1'b0);
    pulse_irq(8'h01);
    ack1(); ack2(8'h20);
    ns_eoi();
    chk("r_lp0", dbg_lp, 0);
    pulse_irq(8'h03);
    chk("r_int", int_o, 1);
    ack1(); ack2(8'h21);
    chk("r_isr1", isr_o, 8'h02);
    ns_eoi();
    chk("r_lp1", dbg_lp, 1);
    ack1(); ack2(8'h20);
    ns_eoi();
    chk("r_lp_back", dbg_lp, 0);

    // spurious: level request withdrawn before ACK1
    cfg(8'h00, 8'h20, 1'b1, 1'b0, 1'b0);
    irq = 8'h10;
    tick(2);
    chk("s_int", int_o, 1);
    chk("s_irr", irr_o, 8'h10);
    irq = 8'h00;
    tick(2);
    chk("s_irr_gone", irr_o, 8'h00);
    ack1(); ack2(8'h27);
    chk("s_isr", isr_o, 8'h00);
    chk("s_lp", dbg_lp, 0);

    // automatic EOI with rotation
    cfg(8'h00, 8'h20, 1'b0, 1'b1, 1'b1);
    pulse_irq(8'h10);
    ack1();
    chk("a_isr_ack1", isr_o, 8'h10);
    ack2(8'h24);
    chk("a_isr_auto", isr_o, 8'h00);
    chk("a_lp", dbg_lp, 4);

    // mask holds a request pending without raising int
    cfg(8'h04, 8'h20, 1'b0, 1'b0, 1'b0);
    pulse_irq(8'h04);
    chk("m_irr", irr_o, 8'h04);
    chk("m_int", int_o, 0);
    cfg(8'h00, 8'h20, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("m_int_unmask", int_o, 1);

    // 32-line instance: wide id and reset during ACK2_WAIT
    cfg_we32 = 1'b1; base32 = 8'h40; tick(1); cfg_we32 = 1'b0;
    irq32 = 32'h8000_0000; tick(1); irq32 = '0; tick(1);
    chk("w_int", int32, 1);
    inta32 = 1'b0; tick(1); inta32 = 1'b1; tick(1);
    exp32_q.push_back(8'h5F);
    inta32 = 1'b0; tick(1); inta32 = 1'b1; tick(1);
    chk("w_vq_empty", exp32_q.size(), 0);
    chk("w_isr", isr32, 32'h8000_0000);
    eoi32 = 1'b1; tick(1); eoi32 = 1'b0;
    irq32 = 32'h8000_0000; tick(1); irq32 = '0; tick(1);
    inta32 = 1'b0; tick(1); inta32 = 1'b1; tick(1);
    chk("w_state_ack2", state32, 2);
    rstn32 = 1'b0;
    #1;
    chk("w_rst_int", int32, 0);
    chk("w_rst_vector", vector32, 0);
    chk("w_rst_vv", vv32, 0);
    chk("w_rst_isr", isr32, 0);
    chk("w_rst_state", state32, 0);
    chk("w_rst_lp", lp32, 31);
    tick(2);
    rstn32 = 1'b1;
    inta32 = 1'b0; tick(1); inta32 = 1'b1; tick(3);
    chk("w_no_vv", exp32_q.size(), 0);
    chk("w_isr_post", isr32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
